f_npc_seq: RTL and testbench
============================

// Module: f_npc_seq
// PURPOSE
//  Fetch-stage next-PC sequencer; consumes the D-stage branch decision (D_cmp_sig) and jump info.
//  Holds F_PC, drives an instruction-memory request/ack handshake, applies taken redirects after the delay slot.
//  Sits between the hazard unit, the D-stage comparator/decoder and IM; also supplies link address (PC+8).
// PARAMETERS
//  RESET_PC  32'h0000_3000  F_PC value after reset
//  IM_BASE   32'h0000_3000  lowest legal fetch address
//  IM_BYTES  32'h0000_4000  legal fetch window size in bytes
// PORTS
//  clk          in   1   single clock, all state on posedge
//  reset        in   1   synchronous, active-high
//  F_stall      in   1   hazard-unit freeze of F/D; D-stage inputs invalid while high
//  D_br         in   1   D instruction is a conditional branch (beq/bltzal)
//  D_cmp_sig    in   1   branch-taken from D comparator
//  D_j          in   1   D instruction is j/jal
//  D_jr         in   1   D instruction is jr
//  D_PC         in   32  PC of D instruction
//  D_imm16      in   16  branch offset (words, signed)
//  D_idx26      in   26  jump instr_index
//  D_jr_tgt     in   32  forwarded rs for jr
//  im_ack       in   1   IM returns instruction at F_PC this cycle
//  im_req       out  1   fetch request for F_PC
//  F_PC         out  32  current fetch address
//  F_fire       out  1   im_req & im_ack & !F_stall: load F/D register
//  D_link_addr  out  32  D_PC + 8 (combinational)
//  F_pc_err     out  1   sticky illegal-fetch flag
//  br_cnt, br_taken_cnt  out  32 each  statistics (see CONFIGURATION)
// BEHAVIOUR
//  Reset: F_PC=RESET_PC, im_req=0, pend_v=0, F_pc_err=0, counters 0, state BOOT.
//  FSM: BOOT -> FETCH unconditionally next cycle (im_req=0 in BOOT). FETCH: im_req=1; stays FETCH.
//  redirect = !F_stall & ((D_br & D_cmp_sig) | D_j | D_jr); D inputs ignored while F_stall=1.
//  Target priority jr > j > br: jr -> D_jr_tgt; j -> {D_PC+4}[31:28],D_idx26,2'b00;
//    br -> D_PC + 4 + (sext(D_imm16)<<2), 32-bit wrap, no overflow detection.
//  Delay slot: redirect never aborts the in-flight fetch (it is the delay slot).
//  On F_fire: F_PC <= pend_v ? pend_tgt : redirect ? tgt : F_PC+4; pend_v <= 0.
//  redirect without F_fire: pend_tgt <= tgt, pend_v <= 1; F_PC unchanged. Second redirect while pend_v
//    overwrites (illegal code only).
//  No F_fire (ack low or stall): F_PC, im_req held; latency per instruction = 1 cycle when ack immediate.
//  F_pc_err set when F_PC[1:0]!=0 or F_PC outside [IM_BASE, IM_BASE+IM_BYTES); cleared only by reset.
//  Reset mid-fetch: outstanding request and pending redirect discarded; restart via BOOT.
// CONFIGURATION
//  BR_STAT_EN defined: br_cnt += 1 per cycle with !F_stall & D_br & F_fire; br_taken_cnt += 1 when also D_cmp_sig.
//    Saturate at 32'hFFFF_FFFF.
//  BR_STAT_EN undefined: no counter registers; br_cnt, br_taken_cnt tied to 0.
// STRUCTURE
//  cpu_defs_pkg: RESET_PC default, state encoding (BOOT/FETCH), CMPop codes shared with D comparator.
//  Sub-module f_npc_calc: combinational target mux (br/j/jr); FSM, PC, pending and stat regs in top.
// TESTING
//  Reset 2 cycles, release, im_ack=1 -> im_req 0 first cycle; F_PC 3000,3000,3004,3008.
//  D_br=1, D_cmp_sig=1, D_PC=3004, imm=0003, im_ack low 2 cycles -> pend_v=1; fire -> F_PC=3014.
//  F_stall=1 with D_j=1 -> F_PC held; no pending; F_stall=0 with D_j, idx=0C01 -> fire, F_PC=3004->3004 target.
//  D_jr=1, D_jr_tgt=3002 -> after fire F_PC=3002, F_pc_err=1, stays 1 after further fires.
//  bltzal not taken, D_PC=3004 -> D_link_addr=300C, F_PC sequential.
//  BR_STAT_EN: 3 branches, 2 taken -> br_cnt=3, br_taken_cnt=2; undefined -> both 0.

Source files
------------

// File: rtl/f_npc_seq_pkg.sv
// Shared definitions for the fetch next-PC sequencer: reset/window defaults,
// FSM state encoding, D-comparator op codes and a saturating increment.
package f_npc_seq_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam logic [31:0] IM_BYTES_DEF = 32'h0000_4000;

    typedef enum logic {
        ST_BOOT  = 1'b0,
        ST_FETCH = 1'b1
    } state_e;

    // Comparison ops implemented by the D-stage comparator that drives D_cmp_sig.
    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_LTZ = 3'd2,
        CMP_GEZ = 3'd3,
        CMP_LEZ = 3'd4,
        CMP_GTZ = 3'd5
    } cmpop_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/f_npc_seq_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and IM (slave).
interface f_npc_seq_if;
    logic        im_req;
    logic        im_ack;
    logic [31:0] F_PC;
    logic        F_fire;

    modport master (output im_req, output F_PC, output F_fire, input im_ack);
    modport slave  (input im_req, input F_PC, input F_fire, output im_ack);
endinterface

// File: rtl/f_npc_seq_calc.sv
// Combinational redirect-target mux for the D-stage control-transfer instruction.
// Priority jr > j > conditional branch.
module f_npc_seq_calc (
    input  logic        D_j_i,
    input  logic        D_jr_i,
    input  logic [31:0] D_PC_i,
    input  logic [15:0] D_imm16_i,
    input  logic [25:0] D_idx26_i,
    input  logic [31:0] D_jr_tgt_i,
    output logic [31:0] tgt_o
);
    logic        [31:0] pc4;
    logic signed [31:0] br_off;
    logic        [31:0] br_tgt;
    logic        [31:0] j_tgt;

    assign pc4    = D_PC_i + 32'd4;
    // Word offset sign-extended then scaled to bytes; the add wraps at 32 bits.
    assign br_off = $signed({{14{D_imm16_i[15]}}, D_imm16_i, 2'b00});
    assign br_tgt = pc4 + $unsigned(br_off);
    assign j_tgt  = {pc4[31:28], D_idx26_i, 2'b00};

    always_comb begin
        tgt_o = br_tgt;
        if (D_jr_i)     tgt_o = D_jr_tgt_i;
        else if (D_j_i) tgt_o = j_tgt;
    end
endmodule

// File: rtl/f_npc_seq.sv
// Fetch-stage next-PC sequencer: holds F_PC, runs the IM handshake, defers taken
// redirects past the delay slot. Optional branch statistics under `BR_STAT_EN.
module f_npc_seq
    import f_npc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter logic [31:0] IM_BYTES = IM_BYTES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               F_stall,
    input  logic               D_br,
    input  logic               D_cmp_sig,
    input  logic               D_j,
    input  logic               D_jr,
    input  logic [31:0]        D_PC,
    input  logic [15:0]        D_imm16,
    input  logic [25:0]        D_idx26,
    input  logic [31:0]        D_jr_tgt,
    f_npc_seq_if.master        im,
    output logic [31:0]        D_link_addr,
    output logic               F_pc_err,
    output logic [31:0]        br_cnt,
    output logic [31:0]        br_taken_cnt
);
    state_e      state_q;
    logic        im_req_q;
    logic [31:0] F_PC_q, F_PC_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_tgt_q;
    logic        err_q, err_d;
    logic        fire, redirect, pc_illegal;
    logic [31:0] tgt;

    f_npc_seq_calc u_calc (
        .D_j_i      (D_j),
        .D_jr_i     (D_jr),
        .D_PC_i     (D_PC),
        .D_imm16_i  (D_imm16),
        .D_idx26_i  (D_idx26),
        .D_jr_tgt_i (D_jr_tgt),
        .tgt_o      (tgt)
    );

    assign fire       = im_req_q & im.im_ack & ~F_stall;
    assign redirect   = ~F_stall & ((D_br & D_cmp_sig) | D_j | D_jr);
    assign pc_illegal = (F_PC_q[1:0] != 2'b00) || (F_PC_q < IM_BASE)
                        || ({1'b0, F_PC_q} >= ({1'b0, IM_BASE} + {1'b0, IM_BYTES}));

    // A redirect never cancels the in-flight fetch: that fetch is the delay slot.
    always_comb begin
        F_PC_d   = F_PC_q;
        pend_v_d = pend_v_q;
        err_d    = err_q | pc_illegal;
        if (fire) begin
            F_PC_d   = pend_v_q ? pend_tgt_q : (redirect ? tgt : F_PC_q + 32'd4);
            pend_v_d = 1'b0;
        end else if (redirect) begin
            pend_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_BOOT;
            im_req_q <= 1'b0;
            F_PC_q   <= RESET_PC;
            pend_v_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q  <= ST_FETCH;
                    im_req_q <= 1'b1;
                end
                default: begin
                    state_q  <= ST_FETCH;
                    im_req_q <= 1'b1;
                end
            endcase
            F_PC_q   <= F_PC_d;
            pend_v_q <= pend_v_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (redirect && !fire) pend_tgt_q <= tgt;
    end

`ifdef BR_STAT_EN
    logic [31:0] br_cnt_q, br_taken_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_q       <= '0;
            br_taken_cnt_q <= '0;
        end else if (fire && D_br) begin
            br_cnt_q <= sat_inc(br_cnt_q);
            if (D_cmp_sig) br_taken_cnt_q <= sat_inc(br_taken_cnt_q);
        end
    end

    assign br_cnt       = br_cnt_q;
    assign br_taken_cnt = br_taken_cnt_q;
`else
    assign br_cnt       = '0;
    assign br_taken_cnt = '0;
`endif

    assign im.im_req   = im_req_q;
    assign im.F_PC     = F_PC_q;
    assign im.F_fire   = fire;
    assign F_pc_err    = err_q;
    assign D_link_addr = D_PC + 32'd8;
endmodule

// File: tb/tb_f_npc_seq.sv
// Self-checking bench for f_npc_seq: directed scenarios plus randomized traffic
// against a behavioural model of the fetch sequencing rules.
module tb_f_npc_seq;
    logic        clk = 1'b0;
    logic        reset, F_stall, D_br, D_cmp_sig, D_j, D_jr;
    logic [31:0] D_PC, D_jr_tgt, D_link_addr, br_cnt, br_taken_cnt;
    logic [15:0] D_imm16;
    logic [25:0] D_idx26;
    logic        F_pc_err;

    f_npc_seq_if im();

    f_npc_seq dut (
        .clk          (clk),
        .reset        (reset),
        .F_stall      (F_stall),
        .D_br         (D_br),
        .D_cmp_sig    (D_cmp_sig),
        .D_j          (D_j),
        .D_jr         (D_jr),
        .D_PC         (D_PC),
        .D_imm16      (D_imm16),
        .D_idx26      (D_idx26),
        .D_jr_tgt     (D_jr_tgt),
        .im           (im),
        .D_link_addr  (D_link_addr),
        .F_pc_err     (F_pc_err),
        .br_cnt       (br_cnt),
        .br_taken_cnt (br_taken_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_pc, m_ptgt, m_br, m_tk;
    logic        m_req, m_pend, m_err;

    function automatic logic [31:0] ref_target();
        logic [31:0] nxt;
        nxt = D_PC + 32'd4;
        if (D_jr) return D_jr_tgt;
        if (D_j)  return {nxt[31:28], D_idx26, 2'b00};
        return nxt + 32'($signed(D_imm16) * 4);
    endfunction

    function automatic bit ref_illegal(input logic [31:0] p);
        return (p % 4 != 0) || (p < 32'h3000) || (p >= 32'h7000);
    endfunction

    task automatic step();
        bit          fire, redir;
        logic [31:0] t;
        t     = ref_target();
        fire  = m_req && im.im_ack && !F_stall;
        redir = !F_stall && ((D_br && D_cmp_sig) || D_j || D_jr);
        @(posedge clk);
        if (reset) begin
            m_pc = 32'h3000; m_req = 0; m_pend = 0; m_err = 0; m_br = 0; m_tk = 0;
        end else begin
            m_err = m_err || ref_illegal(m_pc);
`ifdef BR_STAT_EN
            if (fire && D_br) begin
                if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
                if (D_cmp_sig && m_tk != 32'hFFFF_FFFF) m_tk = m_tk + 1;
            end
`endif
            if (fire) begin
                m_pc   = m_pend ? m_ptgt : (redir ? t : m_pc + 4);
                m_pend = 0;
            end else if (redir) begin
                m_pend = 1;
                m_ptgt = t;
            end
            m_req = 1;
        end
        #1;
    endtask

    task automatic set_idle();
        F_stall = 0; D_br = 0; D_cmp_sig = 0; D_j = 0; D_jr = 0;
        D_PC = 32'h3000; D_imm16 = 0; D_idx26 = 0; D_jr_tgt = 0;
        im.im_ack = 1;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1;
        step(); step();
        total++; if (im.F_PC !== 32'h3000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", im.F_PC, 32'h3000); end
        total++; if (im.im_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", im.im_req); end
        total++; if (F_pc_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", F_pc_err); end
        total++; if (br_cnt !== 0 || br_taken_cnt !== 0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", br_cnt, br_taken_cnt); end
    endtask

    task automatic test_boot_seq();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h3000; exp_pc[1] = 32'h3004; exp_pc[2] = 32'h3008;
        reset = 0;
        #1;
        total++; if (im.im_req !== 1'b0 || im.F_fire !== 1'b0) begin bad++; $display("FAIL boot_req got=%b/%b exp=0/0", im.im_req, im.F_fire); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (im.F_PC !== exp_pc[i]) begin bad++; $display("FAIL boot_pc%0d got=%h exp=%h", i, im.F_PC, exp_pc[i]); end
        end
        total++; if (im.im_req !== 1'b1) begin bad++; $display("FAIL boot_req_on got=%b exp=1", im.im_req); end
    endtask

    task automatic test_pending_redirect();
        im.im_ack = 0; D_br = 1; D_cmp_sig = 1; D_PC = 32'h3004; D_imm16 = 16'h0003;
        step();
        total++; if (im.F_PC !== 32'h3008) begin bad++; $display("FAIL pend_hold1 got=%h exp=%h", im.F_PC, 32'h3008); end
        set_idle(); im.im_ack = 0;
        step();
        total++; if (im.F_PC !== 32'h3008) begin bad++; $display("FAIL pend_hold2 got=%h exp=%h", im.F_PC, 32'h3008); end
        im.im_ack = 1;
        step();
        total++; if (im.F_PC !== 32'h3014) begin bad++; $display("FAIL pend_fire got=%h exp=%h", im.F_PC, 32'h3014); end
        step();
        total++; if (im.F_PC !== 32'h3018) begin bad++; $display("FAIL pend_after got=%h exp=%h", im.F_PC, 32'h3018); end
    endtask

    task automatic test_stall_jump();
        F_stall = 1; D_j = 1; D_idx26 = 26'h0000C01; D_PC = 32'h3010;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (im.F_fire !== 1'b0) begin bad++; $display("FAIL stall_fire got=%b exp=0", im.F_fire); end
            step();
            total++; if (im.F_PC !== 32'h3018) begin bad++; $display("FAIL stall_hold got=%h exp=%h", im.F_PC, 32'h3018); end
        end
        F_stall = 0;
        #1;
        total++; if (im.F_fire !== 1'b1) begin bad++; $display("FAIL jump_fire got=%b exp=1", im.F_fire); end
        step();
        total++; if (im.F_PC !== 32'h3004) begin bad++; $display("FAIL jump_pc got=%h exp=%h", im.F_PC, 32'h3004); end
        set_idle();
        step();
        total++; if (im.F_PC !== 32'h3008) begin bad++; $display("FAIL jump_nopend got=%h exp=%h", im.F_PC, 32'h3008); end
    endtask

    task automatic test_jr_err();
        D_jr = 1; D_jr_tgt = 32'h3002;
        step();
        total++; if (im.F_PC !== 32'h3002) begin bad++; $display("FAIL jr_pc got=%h exp=%h", im.F_PC, 32'h3002); end
        total++; if (F_pc_err !== 1'b0) begin bad++; $display("FAIL jr_err_early got=%b exp=0", F_pc_err); end
        set_idle();
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (F_pc_err !== 1'b1) begin bad++; $display("FAIL jr_err_sticky%0d got=%b exp=1", i, F_pc_err); end
        end
        total++; if (im.F_PC !== 32'h3012) begin bad++; $display("FAIL jr_seq got=%h exp=%h", im.F_PC, 32'h3012); end
        reset = 1;
        step();
        total++; if (F_pc_err !== 1'b0 || im.F_PC !== 32'h3000) begin bad++; $display("FAIL jr_reset got=%b/%h exp=0/3000", F_pc_err, im.F_PC); end
        reset = 0;
        step(); step();
    endtask

    task automatic test_link();
        logic [31:0] exp_pc;
        D_br = 1; D_cmp_sig = 0; D_PC = 32'h3004; D_imm16 = 16'h0010;
        #1;
        total++; if (D_link_addr !== 32'h300C) begin bad++; $display("FAIL link_addr got=%h exp=%h", D_link_addr, 32'h300C); end
        exp_pc = m_pc + 4;
        step();
        total++; if (im.F_PC !== exp_pc) begin bad++; $display("FAIL link_seq got=%h exp=%h", im.F_PC, exp_pc); end
        set_idle();
    endtask

    task automatic test_stats();
        logic [31:0] e_br, e_tk;
        reset = 1; step(); step();
        reset = 0; step();
        D_br = 1; D_PC = 32'h3100; D_imm16 = 0;
        D_cmp_sig = 1; step();
        D_cmp_sig = 0; step();
        D_cmp_sig = 1; step();
        set_idle(); step();
`ifdef BR_STAT_EN
        e_br = 3; e_tk = 2;
`else
        e_br = 0; e_tk = 0;
`endif
        total++; if (br_cnt !== e_br) begin bad++; $display("FAIL stat_br got=%0d exp=%0d", br_cnt, e_br); end
        total++; if (br_taken_cnt !== e_tk) begin bad++; $display("FAIL stat_taken got=%0d exp=%0d", br_taken_cnt, e_tk); end
        total++; if (im.F_PC !== m_pc) begin bad++; $display("FAIL stat_pc got=%h exp=%h", im.F_PC, m_pc); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 99) < 2);
            F_stall   = ($urandom_range(0, 99) < 20);
            im.im_ack = ($urandom_range(0, 99) < 75);
            D_br      = ($urandom_range(0, 99) < 25);
            D_cmp_sig = $urandom_range(0, 1);
            D_j       = ($urandom_range(0, 99) < 8);
            D_jr      = ($urandom_range(0, 99) < 6);
            D_PC      = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
            D_imm16   = 16'($signed($urandom_range(0, 63)) - 32);
            D_idx26   = 26'(32'h0C00 + $urandom_range(0, 32'h0FFF));
            D_jr_tgt  = 32'h3000 + $urandom_range(0, 32'h3FFF);
            #1;
            total++; if (im.F_fire !== (m_req && im.im_ack && !F_stall)) begin bad++; $display("FAIL rnd_fire@%0d got=%b", i, im.F_fire); end
            total++; if (D_link_addr !== D_PC + 8) begin bad++; $display("FAIL rnd_link@%0d got=%h exp=%h", i, D_link_addr, D_PC + 8); end
            step();
            total++; if (im.F_PC !== m_pc) begin bad++; $display("FAIL rnd_pc@%0d got=%h exp=%h", i, im.F_PC, m_pc); end
            total++; if (im.im_req !== m_req) begin bad++; $display("FAIL rnd_req@%0d got=%b exp=%b", i, im.im_req, m_req); end
            total++; if (F_pc_err !== m_err) begin bad++; $display("FAIL rnd_err@%0d got=%b exp=%b", i, F_pc_err, m_err); end
            total++; if (br_cnt !== m_br || br_taken_cnt !== m_tk) begin bad++; $display("FAIL rnd_cnt@%0d got=%0d/%0d exp=%0d/%0d", i, br_cnt, br_taken_cnt, m_br, m_tk); end
        end
        reset = 0;
        set_idle();
    endtask

    initial begin
        reset = 1;
        m_pc = 32'h3000; m_ptgt = 0; m_br = 0; m_tk = 0; m_req = 0; m_pend = 0; m_err = 0;
        set_idle();
        test_reset();
        test_boot_seq();
        test_pending_redirect();
        test_stall_jump();
        test_jr_err();
        test_link();
        test_stats();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
